// File: rtl/bcd_step_counter_if.sv
// Control and status bundle between a controller and the BCD step counter.
// The controller drives enable/direction/preload; the counter returns the decade code and flags.
interface bcd_step_counter_if;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic       step;
  logic       tc;
  logic       err;

  modport master (
    output en, up_dn, load, load_val,
    input  bcd, step, tc, err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output bcd, step, tc, err
  );
endinterface

// File: rtl/bcd_step_counter.sv
// Decade (0-9) up/down counter with a programmable prescaler, synchronous preload,
// registered step/terminal-count pulses and a sticky illegal-preload flag.
module bcd_step_counter #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_step_counter_if.slave  bus
);

  localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [3:0] bcd_q, bcd_d;
  logic       step_q, step_d;
  logic       tc_q, tc_d;
  logic       err_q, err_d;
  logic       tick;
  logic       fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      bcd_q   <= '0;
      step_q  <= 1'b0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    // Resuming from IDLE continues from the held pcnt, so both states advance on en.
    unique case (state_q)
      IDLE: begin
        tick = bus.en;
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        tick = bus.en;
        if (!bus.en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pcnt_d = pcnt_q;
    bcd_d  = bcd_q;
    err_d  = err_q;
    step_d = 1'b0;
    tc_d   = 1'b0;
    fire   = tick && (pcnt_q == PMAX);

    if (bus.load) begin
      pcnt_d = '0;
      if (bus.load_val <= 4'd9) begin
        bcd_d = bus.load_val;
        err_d = 1'b0;
      end else begin
        bcd_d = '0;
        err_d = 1'b1;
      end
    end else if (fire) begin
      pcnt_d = '0;
      step_d = 1'b1;
      if (bus.up_dn) begin
        if (bcd_q >= 4'd9) begin
          bcd_d = '0;
          tc_d  = 1'b1;
        end else begin
          bcd_d = bcd_q + 4'd1;
        end
      end else begin
        if (bcd_q == 4'd0) begin
          bcd_d = 4'd9;
          tc_d  = 1'b1;
        end else if (bcd_q > 4'd9) begin
          bcd_d = 4'd9;
        end else begin
          bcd_d = bcd_q - 4'd1;
        end
      end
    end else if (tick) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.step = step_q;
  assign bus.tc   = tc_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench: DUT a runs with PRESCALE=4, DUT b with PRESCALE=1; shared clock and reset.
module tb_bcd_step_counter;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  bcd_step_counter_if ai();
  bcd_step_counter_if bi();

  bcd_step_counter #(.PRESCALE(4)) dut_a (.clk(clk), .rst(rst), .bus(ai));
  bcd_step_counter #(.PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(bi));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  int unsigned stp_cnt;
  int unsigned tc_cnt;
  logic [3:0] down_seq [6];

  initial begin
    checks = 0;
    errors = 0;
    down_seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
    ai.en = 1'b1; ai.up_dn = 1'b1; ai.load = 1'b0; ai.load_val = '0;
    bi.en = 1'b0; bi.up_dn = 1'b0; bi.load = 1'b0; bi.load_val = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_bcd",  {4'd0, ai.bcd}, 8'd0);
    check("rst_step", {7'd0, ai.step}, 8'd0);
    check("rst_tc",   {7'd0, ai.tc}, 8'd0);
    check("rst_err",  {7'd0, ai.err}, 8'd0);
    cycle();
    rst = 1'b0;

    // Up count, PRESCALE=4: step on every 4th enabled edge, wrap 9->0 at edge 40.
    stp_cnt = 0;
    tc_cnt  = 0;
    for (int e = 1; e <= 44; e++) begin
      cycle();
      check("up_bcd",  {4'd0, ai.bcd}, 8'((e / 4) % 10));
      check("up_step", {7'd0, ai.step}, {7'd0, (e % 4) == 0});
      check("up_tc",   {7'd0, ai.tc}, {7'd0, e == 40});
      if (ai.step) stp_cnt++;
      if (ai.tc) tc_cnt++;
    end
    check("up_step_total", 8'(stp_cnt), 8'd11);
    check("up_tc_total",   8'(tc_cnt), 8'd1);
    ai.en = 1'b0;

    // Preload 5 then down count with PRESCALE=1.
    bi.load = 1'b1; bi.load_val = 4'd5;
    cycle();
    check("ld5_bcd",  {4'd0, bi.bcd}, 8'd5);
    check("ld5_step", {7'd0, bi.step}, 8'd0);
    bi.load = 1'b0; bi.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("dn_bcd",  {4'd0, bi.bcd}, {4'd0, down_seq[i]});
      check("dn_step", {7'd0, bi.step}, 8'd1);
      check("dn_tc",   {7'd0, bi.tc}, {7'd0, i == 5});
    end
    bi.en = 1'b0;
    cycle();
    check("dn_idle_step", {7'd0, bi.step}, 8'd0);
    check("dn_idle_tc",   {7'd0, bi.tc}, 8'd0);
    check("dn_idle_bcd",  {4'd0, bi.bcd}, 8'd9);

    // Illegal and legal preloads.
    bi.load = 1'b1; bi.load_val = 4'd12;
    cycle();
    check("ld12_bcd", {4'd0, bi.bcd}, 8'd0);
    check("ld12_err", {7'd0, bi.err}, 8'd1);
    bi.load = 1'b0;
    cycle();
    check("err_sticky", {7'd0, bi.err}, 8'd1);
    bi.load = 1'b1; bi.load_val = 4'd7;
    cycle();
    check("ld7_bcd", {4'd0, bi.bcd}, 8'd7);
    check("ld7_err", {7'd0, bi.err}, 8'd0);
    bi.load = 1'b0;

    rst = 1'b1;
    #1;
    check("rst2_bcd_b", {4'd0, bi.bcd}, 8'd0);
    rst = 1'b0;

    // Pause: pcnt reaches 2, holds through en=0, step on 2nd enabled edge after resume.
    ai.en = 1'b1; ai.up_dn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("ps_run_bcd",  {4'd0, ai.bcd}, 8'd0);
      check("ps_run_step", {7'd0, ai.step}, 8'd0);
    end
    ai.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("ps_hold_bcd",  {4'd0, ai.bcd}, 8'd0);
      check("ps_hold_step", {7'd0, ai.step}, 8'd0);
    end
    ai.en = 1'b1;
    cycle();
    check("ps_res1_bcd",  {4'd0, ai.bcd}, 8'd0);
    check("ps_res1_step", {7'd0, ai.step}, 8'd0);
    cycle();
    check("ps_res2_bcd",  {4'd0, ai.bcd}, 8'd1);
    check("ps_res2_step", {7'd0, ai.step}, 8'd1);

    // Collision: load on the step-qualifying edge wins and restarts the prescaler.
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("col_pre_bcd", {4'd0, ai.bcd}, 8'd1);
    end
    ai.load = 1'b1; ai.load_val = 4'd3;
    cycle();
    check("col_bcd",  {4'd0, ai.bcd}, 8'd3);
    check("col_step", {7'd0, ai.step}, 8'd0);
    check("col_tc",   {7'd0, ai.tc}, 8'd0);
    ai.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("col_wait_bcd",  {4'd0, ai.bcd}, 8'd3);
      check("col_wait_step", {7'd0, ai.step}, 8'd0);
    end
    cycle();
    check("col_next_bcd",  {4'd0, ai.bcd}, 8'd4);
    check("col_next_step", {7'd0, ai.step}, 8'd1);
    ai.en = 1'b0;

    // Async reset between edges while bcd=8, step/err high.
    bi.load = 1'b1; bi.load_val = 4'd15;
    cycle();
    check("ld15_err", {7'd0, bi.err}, 8'd1);
    bi.load = 1'b0; bi.en = 1'b1; bi.up_dn = 1'b0;
    cycle();
    check("ar_wrap_bcd", {4'd0, bi.bcd}, 8'd9);
    check("ar_wrap_tc",  {7'd0, bi.tc}, 8'd1);
    cycle();
    check("ar_pre_bcd",  {4'd0, bi.bcd}, 8'd8);
    check("ar_pre_step", {7'd0, bi.step}, 8'd1);
    bi.en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("ar_bcd",  {4'd0, bi.bcd}, 8'd0);
    check("ar_step", {7'd0, bi.step}, 8'd0);
    check("ar_tc",   {7'd0, bi.tc}, 8'd0);
    check("ar_err",  {7'd0, bi.err}, 8'd0);
    #1 rst = 1'b0;
    cycle();
    check("ar_post_step", {7'd0, bi.step}, 8'd0);
    check("ar_post_tc",   {7'd0, bi.tc}, 8'd0);
    check("ar_post_bcd",  {4'd0, bi.bcd}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
